trap_span_walker: RTL and testbench

Parametrised successor to the trapezoid edge search. It walks a horizontal-edged trapezoid from yd to yu and produces one inclusive pixel span [xl, xr] per scanline. Edge x positions are computed by exact incremental DDA: one sequential divide per edge at setup, then one step per scanline. No external multiply-adder is used. Spans leave on a valid/ready stream that feeds the pixel output stage.

---
 rtl/trap_span_walker_pkg.sv | 20 ++
 rtl/trap_span_walker_edge.sv | 91 +++++++++
 rtl/trap_span_walker.sv | 201 ++++++++++++++++++++
 tb/tb_trap_span_walker.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_span_walker_pkg.sv
// Shared types for the trapezoid span walker: FSM encoding and the span record.
package trap_span_walker_pkg;

    localparam int CW_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_EMIT
    } state_t;

    typedef struct packed {
        logic [CW_DEF-1:0] y;
        logic [CW_DEF-1:0] xl;
        logic [CW_DEF-1:0] xr;
        logic              empty;
    } span_t;

endpackage

// File: rtl/trap_span_walker_edge.sv
// One trapezoid edge: restoring divide m/h at setup, then exact Q/R DDA stepping.
// use_ceil selects the inside-rounding for a left (ceil) or right (floor) edge.
module trap_edge_dda
    import trap_span_walker_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          use_ceil,
    input  logic          load,
    input  logic          div_step,
    input  logic          step,
    input  logic [CW-1:0] x_bot,
    input  logic [CW-1:0] x_top,
    input  logic [CW-1:0] h,
    output logic [CW-1:0] x
);

    logic [CW:0]   rem_q, rem_d;
    logic [CW-1:0] quo_q, quo_d;
    logic [CW-1:0] qacc_q, qacc_d;
    logic [CW:0]   racc_q, racc_d;

    logic          s;
    logic [CW-1:0] m;
    logic [CW:0]   trial;
    logic [CW:0]   r_sum;
    logic [CW-1:0] q_sum;
    logic [CW:0]   h_w;
    logic          frac;

    always_comb begin
        s      = (x_top < x_bot);
        m      = s ? (x_bot - x_top) : (x_top - x_bot);
        h_w    = {1'b0, h};
        rem_d  = rem_q;
        quo_d  = quo_q;
        qacc_d = qacc_q;
        racc_d = racc_q;
        // The quotient register starts as the dividend and shifts quotient bits in.
        trial  = {rem_q[CW-1:0], quo_q[CW-1]};
        r_sum  = racc_q + rem_q;
        q_sum  = qacc_q + quo_q;

        if (load) begin
            rem_d  = '0;
            quo_d  = (h == '0) ? '0 : m;
            qacc_d = '0;
            racc_d = '0;
        end else if (div_step) begin
            if (trial >= h_w) begin
                rem_d = trial - h_w;
                quo_d = {quo_q[CW-2:0], 1'b1};
            end else begin
                rem_d = trial;
                quo_d = {quo_q[CW-2:0], 1'b0};
            end
        end else if (step) begin
            if (r_sum >= h_w) begin
                racc_d = r_sum - h_w;
                qacc_d = q_sum + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                racc_d = r_sum;
                qacc_d = q_sum;
            end
        end

        frac = (racc_q != '0);
        if (!s) begin
            x = x_bot + qacc_q + {{(CW-1){1'b0}}, use_ceil & frac};
        end else begin
            x = x_bot - qacc_q - {{(CW-1){1'b0}}, ~use_ceil & frac};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            qacc_q <= '0;
            racc_q <= '0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            qacc_q <= qacc_d;
            racc_q <= racc_d;
        end
    end

endmodule

// File: rtl/trap_span_walker.sv
// Walks a horizontal-edged trapezoid from yd to yu, one inclusive span per scanline.
// Setup is LOAD + CW divide cycles; spans stream at 1/cycle and hold while span_ready=0.
module trap_span_walker
    import trap_span_walker_pkg::*;
#(
    parameter int CW         = CW_DEF,
    parameter bit SKIP_EMPTY = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] yd,
    input  logic [CW-1:0] yu,
    input  logic [CW-1:0] xdl,
    input  logic [CW-1:0] xul,
    input  logic [CW-1:0] xdr,
    input  logic [CW-1:0] xur,
    output logic          busy,
    output logic          span_valid,
    input  logic          span_ready,
    output logic [CW-1:0] span_y,
    output logic [CW-1:0] span_xl,
    output logic [CW-1:0] span_xr,
    output logic          span_empty,
    output logic          done,
    output logic          err
);

    localparam int CNT_W = $clog2(CW + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] yd_q, yd_d, yu_q, yu_d;
    logic [CW-1:0] xdl_q, xdl_d, xul_q, xul_d, xdr_q, xdr_d, xur_q, xur_d;
    logic [CW-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          span_valid_q, span_valid_d;
    logic [CW-1:0] span_y_q, span_y_d, span_xl_q, span_xl_d, span_xr_q, span_xr_d;
    logic          span_empty_q, span_empty_d;
    logic          done_q, done_d, err_q, err_d;

    logic          load, div_step, step;
    logic [CW-1:0] h, xl, xr;
    logic          line_empty;

    assign h = yu_q - yd_q;

    trap_edge_dda #(.CW(CW)) u_left (
        .clk(clk), .reset(reset), .use_ceil(1'b1),
        .load(load), .div_step(div_step), .step(step),
        .x_bot(xdl_q), .x_top(xul_q), .h(h), .x(xl)
    );

    trap_edge_dda #(.CW(CW)) u_right (
        .clk(clk), .reset(reset), .use_ceil(1'b0),
        .load(load), .div_step(div_step), .step(step),
        .x_bot(xdr_q), .x_top(xur_q), .h(h), .x(xr)
    );

    always_comb begin
        state_d      = state_q;
        yd_d         = yd_q;
        yu_d         = yu_q;
        xdl_d        = xdl_q;
        xul_d        = xul_q;
        xdr_d        = xdr_q;
        xur_d        = xur_q;
        y_d          = y_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        span_valid_d = span_valid_q;
        span_y_d     = span_y_q;
        span_xl_d    = span_xl_q;
        span_xr_d    = span_xr_q;
        span_empty_d = span_empty_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        load         = 1'b0;
        div_step     = 1'b0;
        step         = 1'b0;
        line_empty   = (xl > xr);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    yd_d    = yd;
                    yu_d    = yu;
                    xdl_d   = xdl;
                    xul_d   = xul;
                    xdr_d   = xdr;
                    xur_d   = xur;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (yu_q < yd_q) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    load    = 1'b1;
                    y_d     = yd_q;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = (h == '0) ? S_EMIT : S_DIV;
                end
            end
            S_DIV: begin
                div_step = 1'b1;
                cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(CW - 1)) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                // y_q is the next line to present; the output slot frees on accept.
                if (!span_valid_q || span_ready) begin
                    if (last_q) begin
                        span_valid_d = 1'b0;
                        done_d       = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        span_y_d     = y_q;
                        span_xl_d    = xl;
                        span_xr_d    = xr;
                        span_empty_d = line_empty;
                        span_valid_d = !(line_empty && SKIP_EMPTY);
                        if (y_q == yu_q) begin
                            last_d = 1'b1;
                        end else begin
                            y_d  = y_q + {{(CW-1){1'b0}}, 1'b1};
                            step = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d      = S_IDLE;
            span_valid_d = 1'b0;
            done_d       = 1'b0;
            err_d        = 1'b0;
            load         = 1'b0;
            div_step     = 1'b0;
            step         = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            yd_q         <= '0;
            yu_q         <= '0;
            xdl_q        <= '0;
            xul_q        <= '0;
            xdr_q        <= '0;
            xur_q        <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            span_valid_q <= 1'b0;
            span_y_q     <= '0;
            span_xl_q    <= '0;
            span_xr_q    <= '0;
            span_empty_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            yd_q         <= yd_d;
            yu_q         <= yu_d;
            xdl_q        <= xdl_d;
            xul_q        <= xul_d;
            xdr_q        <= xdr_d;
            xur_q        <= xur_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            span_valid_q <= span_valid_d;
            span_y_q     <= span_y_d;
            span_xl_q    <= span_xl_d;
            span_xr_q    <= span_xr_d;
            span_empty_q <= span_empty_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign span_valid = span_valid_q;
    assign span_y     = span_y_q;
    assign span_xl    = span_xl_q;
    assign span_xr    = span_xr_q;
    assign span_empty = span_empty_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_trap_span_walker.sv
// Directed bench: one walker with empty-line skipping, one without, on shared stimulus.
module tb_trap_span_walker;
    import trap_span_walker_pkg::*;

    typedef struct {
        logic [7:0] yd, yu, xdl, xul, xdr, xur;
        int         off;
        int         n;
        int         err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, start, abort, span_ready;
    logic [7:0] yd, yu, xdl, xul, xdr, xur;

    logic       a_busy, a_valid, a_empty, a_done, a_err;
    logic [7:0] a_y, a_xl, a_xr;
    logic       k_busy, k_valid, k_empty, k_done, k_err;
    logic [7:0] k_y, k_xl, k_xr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rmode    = 0;
    int st_cyc   = 0;

    vec_t  vt [0:4];
    span_t es [0:15];
    span_t got [2][0:15];
    int    got_n [2];
    int    first_vld [2];
    int    last_hs [2];
    int    done_cyc [2];
    int    done_n [2];
    int    err_n [2];
    logic  hold_prev [2];
    span_t prev_sp [2];

    logic  vld [2];
    logic  dn [2];
    logic  er [2];
    span_t cur [2];

    assign vld[0] = a_valid;
    assign vld[1] = k_valid;
    assign dn[0]  = a_done;
    assign dn[1]  = k_done;
    assign er[0]  = a_err;
    assign er[1]  = k_err;
    assign cur[0] = {a_y, a_xl, a_xr, a_empty};
    assign cur[1] = {k_y, k_xl, k_xr, k_empty};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    trap_span_walker #(.CW(8), .SKIP_EMPTY(1'b1)) u_skip (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .yd(yd), .yu(yu), .xdl(xdl), .xul(xul), .xdr(xdr), .xur(xur),
        .busy(a_busy), .span_valid(a_valid), .span_ready(span_ready),
        .span_y(a_y), .span_xl(a_xl), .span_xr(a_xr), .span_empty(a_empty),
        .done(a_done), .err(a_err)
    );

    trap_span_walker #(.CW(8), .SKIP_EMPTY(1'b0)) u_keep (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .yd(yd), .yu(yu), .xdl(xdl), .xul(xul), .xdr(xdr), .xur(xur),
        .busy(k_busy), .span_valid(k_valid), .span_ready(span_ready),
        .span_y(k_y), .span_xl(k_xl), .span_xr(k_xr), .span_empty(k_empty),
        .done(k_done), .err(k_err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_span(input string nm, input span_t act, input span_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got (y=%0d xl=%0d xr=%0d e=%0b), expected (y=%0d xl=%0d xr=%0d e=%0b)",
                     nm, act.y, act.xl, act.xr, act.empty, exp.y, exp.xl, exp.xr, exp.empty);
        end
    endtask

    function automatic span_t mk(input int y, input int xl, input int xr, input bit e);
        span_t s;
        s.y     = 8'(y);
        s.xl    = 8'(xl);
        s.xr    = 8'(xr);
        s.empty = e;
        return s;
    endfunction

    // Handshake capture, hold-stability and done/err accounting, sampled mid-cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (hold_prev[d]) begin
                chk_span($sformatf("hold_stable dut%0d", d), vld[d] ? cur[d] : ~prev_sp[d], prev_sp[d]);
            end
            if (vld[d] && span_ready) begin
                if (got_n[d] < 16) got[d][got_n[d]] = cur[d];
                got_n[d]++;
                last_hs[d] = cyc;
            end
            if (vld[d] && first_vld[d] < 0) first_vld[d] = cyc;
            if (dn[d]) begin
                done_n[d]++;
                done_cyc[d] = cyc;
            end
            if (er[d]) begin
                err_n[d]++;
                chk($sformatf("err_with_done dut%0d", d), int'(dn[d]), 1);
            end
            hold_prev[d] = vld[d] && !span_ready && !abort && !reset;
            prev_sp[d]   = cur[d];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rmode)
            0:       span_ready = 1'b1;
            1:       span_ready = (cyc % 3 == 0);
            default: span_ready = 1'b0;
        endcase
    endtask

    task automatic clear_obs();
        for (int d = 0; d < 2; d++) begin
            got_n[d]     = 0;
            first_vld[d] = -1;
            last_hs[d]   = -1;
            done_cyc[d]  = -1;
        end
    endtask

    task automatic start_vec(input vec_t v);
        yd    = v.yd;
        yu    = v.yu;
        xdl   = v.xdl;
        xul   = v.xul;
        xdr   = v.xdr;
        xur   = v.xur;
        start = 1'b1;
        tick();
        start  = 1'b0;
        st_cyc = cyc;
    endtask

    task automatic run_vec(input int vi);
        vec_t  v;
        int    b_done [2];
        int    b_err [2];
        int    ne;
        span_t sp;
        v = vt[vi];
        clear_obs();
        for (int d = 0; d < 2; d++) begin
            b_done[d] = done_n[d];
            b_err[d]  = err_n[d];
        end
        start_vec(v);
        for (int t = 0; t < 300; t++) begin
            if (done_n[0] > b_done[0] && done_n[1] > b_done[1]) break;
            tick();
        end
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            ne = 0;
            for (int j = 0; j < v.n; j++) begin
                sp = es[v.off + j];
                if (d == 1 || !sp.empty) begin
                    if (ne < got_n[d] && ne < 16)
                        chk_span($sformatf("span v%0d m%0d dut%0d #%0d", vi, rmode, d, ne), got[d][ne], sp);
                    ne++;
                end
            end
            chk($sformatf("span_count v%0d m%0d dut%0d", vi, rmode, d), got_n[d], ne);
            chk($sformatf("done_count v%0d m%0d dut%0d", vi, rmode, d), done_n[d] - b_done[d], 1);
            chk($sformatf("err_count v%0d m%0d dut%0d", vi, rmode, d), err_n[d] - b_err[d], v.err);
        end
        chk($sformatf("idle_busy v%0d m%0d", vi, rmode), int'(a_busy) + int'(k_busy), 0);
    endtask

    initial begin
        int b_done0;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        span_ready = 1'b1;
        {yd, yu, xdl, xul, xdr, xur} = '0;
        for (int d = 0; d < 2; d++) begin
            done_n[d]    = 0;
            err_n[d]     = 0;
            hold_prev[d] = 1'b0;
            prev_sp[d]   = '0;
        end
        clear_obs();

        vt[0] = '{yd: 10, yu: 14, xdl: 20, xul: 24, xdr: 40, xur: 30, off: 0,  n: 5, err: 0};
        vt[1] = '{yd: 0,  yu: 2,  xdl: 0,  xul: 3,  xdr: 9,  xur: 9,  off: 5,  n: 3, err: 0};
        vt[2] = '{yd: 0,  yu: 3,  xdl: 10, xul: 10, xdr: 12, xur: 6,  off: 8,  n: 4, err: 0};
        vt[3] = '{yd: 5,  yu: 5,  xdl: 3,  xul: 3,  xdr: 7,  xur: 7,  off: 12, n: 1, err: 0};
        vt[4] = '{yd: 5,  yu: 4,  xdl: 3,  xul: 3,  xdr: 7,  xur: 7,  off: 13, n: 0, err: 1};
        es[0]  = mk(10, 20, 40, 0);
        es[1]  = mk(11, 21, 37, 0);
        es[2]  = mk(12, 22, 35, 0);
        es[3]  = mk(13, 23, 32, 0);
        es[4]  = mk(14, 24, 30, 0);
        es[5]  = mk(0, 0, 9, 0);
        es[6]  = mk(1, 2, 9, 0);
        es[7]  = mk(2, 3, 9, 0);
        es[8]  = mk(0, 10, 12, 0);
        es[9]  = mk(1, 10, 10, 0);
        es[10] = mk(2, 10, 8, 1);
        es[11] = mk(3, 10, 6, 1);
        es[12] = mk(5, 3, 7, 0);
        for (int j = 13; j < 16; j++) es[j] = '0;

        repeat (3) tick();
        chk("rst_busy", int'(a_busy) + int'(k_busy), 0);
        chk("rst_valid", int'(a_valid) + int'(k_valid), 0);
        chk("rst_done_err", int'(a_done) + int'(a_err) + int'(k_done) + int'(k_err), 0);
        chk("rst_span", int'({a_y, a_xl, a_xr, a_empty}), 0);
        reset = 1'b0;
        tick();

        rmode = 0;
        for (int vi = 0; vi < 5; vi++) run_vec(vi);
        rmode = 1;
        for (int vi = 0; vi < 5; vi++) run_vec(vi);
        rmode = 0;
        tick();

        // First-span latency and done timing.
        run_vec(0);
        chk("latency_h4", first_vld[0] - st_cyc, 10);
        chk("done_after_last", done_cyc[0] - last_hs[0], 1);
        run_vec(3);
        chk("latency_h0", first_vld[0] - st_cyc, 2);

        // Abort after the second accepted span.
        clear_obs();
        b_done0 = done_n[0];
        start_vec(vt[0]);
        for (int t = 0; t < 100; t++) begin
            if (got_n[0] >= 2) break;
            tick();
        end
        abort      = 1'b1;
        rmode      = 2;
        span_ready = 1'b0;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", int'(a_valid), 0);
        chk("abort_busy", int'(a_busy) + int'(k_busy), 0);
        repeat (4) tick();
        chk("abort_spans", got_n[0], 2);
        chk("abort_no_done", done_n[0] - b_done0, 0);
        rmode = 0;
        tick();
        run_vec(0);

        // Abort and start together in IDLE.
        yd    = 8'd10;
        yu    = 8'd14;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        chk("abort_beats_start", int'(a_busy), 0);

        // Asynchronous reset mid-walk.
        start_vec(vt[0]);
        repeat (4) tick();
        chk("pre_reset_busy", int'(a_busy), 1);
        reset = 1'b1;
        #1;
        chk("async_reset_busy", int'(a_busy) + int'(k_busy), 0);
        tick();
        reset = 1'b0;
        tick();
        run_vec(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
